// File: rtl/cordic_sqrt_scalar.sv
// Iterative unsigned square root: 32-bit radicand to 16-bit root, one root bit per clock, 16 cycles.
// Optional macro CORDIC_SQRT_ROUND_EN switches the final result from floor to round-to-nearest.
module cordic_sqrt_scalar (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] value_in,
    output logic [15:0] sqrt_out,
    output logic        valid
);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] operand;
    logic [17:0] rem;
    logic [15:0] root;
    logic [3:0]  iter;

    logic [17:0] rem_shift;
    logic [17:0] trial;
    logic        take;
    logic [17:0] rem_next;
    logic [15:0] root_next;
    logic [15:0] result;

    // Start handshake: start is a single-cycle request, accepted only on an
    // edge where the block is IDLE; requests seen during CALC are dropped.
    // valid is a one-cycle completion pulse with no back-pressure.

    always_comb begin
        rem_shift = {rem[15:0], operand[31:30]};
        trial     = {root, 2'b01};
        // Bits shifted out of the remainder would mean it certainly exceeds the trial.
        take      = (rem[17:16] != 2'b00) || (rem_shift >= trial);
        rem_next  = take ? (rem_shift - trial) : rem_shift;
        root_next = {root[14:0], take};
`ifdef CORDIC_SQRT_ROUND_EN
        if ((rem_next > {2'b00, root_next}) && (root_next != 16'hFFFF))
            result = root_next + 16'd1;
        else
            result = root_next;
`else
        result = root_next;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            operand  <= 32'd0;
            rem      <= 18'd0;
            root     <= 16'd0;
            iter     <= 4'd0;
            sqrt_out <= 16'd0;
            valid    <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        operand <= value_in;
                        rem     <= 18'd0;
                        root    <= 16'd0;
                        iter    <= 4'd15;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    operand <= {operand[29:0], 2'b00};
                    rem     <= rem_next;
                    root    <= root_next;
                    iter    <= iter - 4'd1;
                    if (iter == 4'd0) begin
                        sqrt_out <= result;
                        valid    <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_sqrt_scalar.sv
// Bench for cordic_sqrt_scalar: vector table plus hand sequences for
// ignored starts, back-to-back accepts and mid-computation reset.
module tb_cordic_sqrt_scalar;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] value_in;
    logic [15:0] sqrt_out;
    logic        valid;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];

    typedef struct {
        logic [31:0] v;
        logic [15:0] fl;
        logic [15:0] rd;
    } vec_t;

    vec_t vecs[14];

    cordic_sqrt_scalar dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .value_in (value_in),
        .sqrt_out (sqrt_out),
        .valid    (valid)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Independent reference: bitwise search on squares, not shift-subtract.
    function automatic logic [15:0] ref_sqrt(input logic [31:0] v);
        logic [63:0] r;
        logic [63:0] t;
        r = 64'd0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= {32'd0, v}) r = t;
        end
`ifdef CORDIC_SQRT_ROUND_EN
        if (({32'd0, v} - r * r) > r) r = r + 64'd1;
        if (r > 64'd65535) r = 64'd65535;
`endif
        return r[15:0];
    endfunction

    // Scoreboard: every valid pulse pops one expected root.
    always @(negedge clk) begin
        if (reset_n && valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got sqrt_out=%0d expected no pulse at %0t", sqrt_out, $time);
            end else begin
                check("sqrt_out", {16'd0, sqrt_out}, {16'd0, exp_q.pop_front()});
            end
        end
    end

    // Driver: one request, then a 20-cycle window measuring latency and pulse
    // count; optional extra start pulse at window cycle inj_k.
    task automatic do_op(input logic [31:0] v, input logic [15:0] e, input int inj_k, input logic [31:0] inj_v);
        int lat;
        int pulses;
        @(negedge clk);
        start    = 1'b1;
        value_in = v;
        exp_q.push_back(e);
        @(negedge clk);
        start    = 1'b0;
        value_in = $urandom;
        lat      = 0;
        pulses   = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == inj_k) begin
                start    = 1'b1;
                value_in = inj_v;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (valid) begin
                pulses++;
                if (lat == 0) lat = k;
            end
        end
        start = 1'b0;
        check("latency", lat, 16);
        check("pulse_count", pulses, 1);
        check("hold", {16'd0, sqrt_out}, {16'd0, e});
    endtask

    initial begin
        vecs[0]  = '{32'd0,          16'd0,     16'd0};
        vecs[1]  = '{32'd1,          16'd1,     16'd1};
        vecs[2]  = '{32'd4,          16'd2,     16'd2};
        vecs[3]  = '{32'd9,          16'd3,     16'd3};
        vecs[4]  = '{32'd16,         16'd4,     16'd4};
        vecs[5]  = '{32'd25,         16'd5,     16'd5};
        vecs[6]  = '{32'd100,        16'd10,    16'd10};
        vecs[7]  = '{32'd2,          16'd1,     16'd1};
        vecs[8]  = '{32'd3,          16'd1,     16'd2};
        vecs[9]  = '{32'd5,          16'd2,     16'd2};
        vecs[10] = '{32'd8,          16'd2,     16'd3};
        vecs[11] = '{32'd15,         16'd3,     16'd4};
        vecs[12] = '{32'hFFFF_FFFF,  16'd65535, 16'd65535};
        vecs[13] = '{32'hFFFE_0001,  16'd65535, 16'd65535};

        reset_n  = 1'b0;
        start    = 1'b0;
        value_in = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_sqrt_out", {16'd0, sqrt_out}, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
`ifdef CORDIC_SQRT_ROUND_EN
            do_op(vecs[i].v, vecs[i].rd, 0, 32'd0);
`else
            do_op(vecs[i].v, vecs[i].fl, 0, 32'd0);
`endif
        end

        for (int i = 0; i < 6; i++) begin
            logic [31:0] rv;
            rv = $urandom;
            if (i < 3) rv = rv >> $urandom_range(31, 8);
            do_op(rv, ref_sqrt(rv), 0, 32'd0);
        end

        // Start during CALC is ignored: one result, one pulse.
        do_op(32'hFFFF_FFFF, 16'd65535, 5, 32'd7);

        // Back-to-back: next start issued in the cycle valid is high.
        @(negedge clk);
        start    = 1'b1;
        value_in = 32'd25;
        exp_q.push_back(16'd5);
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        check("b2b_first_valid", {31'd0, valid}, 32'd1);
        start    = 1'b1;
        value_in = 32'd16;
        exp_q.push_back(16'd4);
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        check("b2b_second_valid", {31'd0, valid}, 32'd1);
        @(negedge clk);
        check("b2b_pulse_end", {31'd0, valid}, 32'd0);

        // Reset in the middle of a computation.
        @(negedge clk);
        start    = 1'b1;
        value_in = 32'd100;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset_sqrt_out", {16'd0, sqrt_out}, 32'd0);
        check("midreset_valid", {31'd0, valid}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        begin
            int pulses;
            pulses = 0;
            repeat (20) begin
                @(negedge clk);
                if (valid) pulses++;
            end
            check("midreset_no_pulse", pulses, 0);
            check("midreset_hold", {16'd0, sqrt_out}, 32'd0);
        end
        do_op(32'd9, 16'd3, 0, 32'd0);

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
